// File: rtl/ccff_cfg_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
package ccff_cfg_pkg;

  // Controller states.
  typedef enum logic [2:0] {
    StIdle,
    StWaitWord,
    StShift,
    StRbHold,
    StDone
  } state_e;

  // One ble4: 16 LUT4 bits plus 2 output-mux select bits.
  localparam int unsigned BLE4_CHAIN_LEN = 18;

  // Bits needed to hold a count from 0 to max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word-wide PISO feeding ccff_head and SIPO collecting ccff_tail bits.
// Load clears the capture register so unused high bits of a short word read back as zero.
module ccff_word_serializer #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned IDX_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] data_i,
  input  logic [IDX_W-1:0]  bit_idx_i,
  input  logic              tail_i,
  output logic              head_o,
  output logic [WORD_W-1:0] capture_o
);

  logic [WORD_W-1:0] piso_q, piso_d;
  logic [WORD_W-1:0] sipo_q, sipo_d;

  // Next-state for both shift registers.
  always_comb begin
    piso_d = piso_q;
    sipo_d = sipo_q;
    if (load_i) begin
      piso_d = data_i;
      sipo_d = '0;
    end else if (shift_i) begin
      piso_d = piso_q >> 1;
      for (int i = 0; i < int'(WORD_W); i++) begin
        if (IDX_W'(i) == bit_idx_i) begin
          sipo_d[i] = tail_i;
        end
      end
    end
  end

  // Register both halves; synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      piso_q <= '0;
      sipo_q <= '0;
    end else begin
      piso_q <= piso_d;
      sipo_q <= sipo_d;
    end
  end

  // Head bit comes straight from a flop so the chain input is glitch-free.
  assign head_o    = piso_q[0];
  assign capture_o = sipo_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a tile configuration chain from a word stream, one prog_clk enable per bit,
// and returns the displaced chain contents as readback words.
module ccff_chain_loader
  import ccff_cfg_pkg::*;
#(
  parameter int unsigned CHAIN_LEN   = BLE4_CHAIN_LEN,
  parameter int unsigned WORD_W      = 8,
  parameter bit          READBACK_EN = 1'b1
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [WORD_W-1:0] cfg_data,
  output logic              ccff_head,
  output logic              prog_clk_en,
  input  logic              ccff_tail,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              busy,
  output logic              cfg_done,
  output logic              cfg_err
);

  localparam int unsigned CNT_W = cnt_width(CHAIN_LEN);
  localparam int unsigned IDX_W = cnt_width(WORD_W);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bits_q, bits_d;
  logic [IDX_W-1:0]  len_q, len_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              rb_valid_q, rb_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              pclk_en_q;
  logic              load, shift;
  logic [IDX_W-1:0]  word_len;
  logic [WORD_W-1:0] capture;
  logic [31:0]       remaining;

  assign cfg_ready   = (state_q == StWaitWord) && !rb_valid_q;
  assign prog_clk_en = pclk_en_q;
  assign rb_valid    = rb_valid_q;
  assign rb_data     = READBACK_EN ? capture : '0;
  assign busy        = busy_q;
  assign cfg_done    = done_q;
  assign cfg_err     = err_q;

  // Bits in the next word: a full word, or whatever is left of the chain.
  always_comb begin
    remaining = CHAIN_LEN - 32'(bits_q);
    word_len  = (remaining < WORD_W) ? IDX_W'(remaining) : IDX_W'(WORD_W);
  end

  // Session FSM, counters and handshakes.
  always_comb begin
    state_d    = state_q;
    bits_d     = bits_q;
    len_d      = len_q;
    idx_d      = idx_q;
    rb_valid_d = rb_valid_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    load       = 1'b0;
    shift      = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (cfg_start) begin
          state_d = StWaitWord;
          bits_d  = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      StWaitWord: begin
        if (cfg_start) err_d = 1'b1;
        if (cfg_valid && cfg_ready) begin
          load    = 1'b1;
          len_d   = word_len;
          idx_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (cfg_start) err_d = 1'b1;
        shift  = 1'b1;
        idx_d  = idx_q + IDX_W'(1);
        bits_d = bits_q + CNT_W'(1);
        if (idx_d == len_q) begin
          if (READBACK_EN) begin
            rb_valid_d = 1'b1;
            state_d    = StRbHold;
          end else if (bits_d == CNT_W'(CHAIN_LEN)) begin
            state_d = StDone;
          end else begin
            state_d = StWaitWord;
          end
        end
      end
      StRbHold: begin
        if (cfg_start) err_d = 1'b1;
        if (rb_ready) begin
          rb_valid_d = 1'b0;
          state_d    = (bits_q == CNT_W'(CHAIN_LEN)) ? StDone : StWaitWord;
        end
      end
      default: state_d = StIdle;
    endcase

    if ((state_d == StDone) && (state_q != StDone)) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end

    // Abort beats everything else, including a simultaneous start.
    if (cfg_abort) begin
      state_d    = StIdle;
      rb_valid_d = 1'b0;
      busy_d     = 1'b0;
      load       = 1'b0;
      shift      = 1'b0;
      bits_d     = bits_q;
      len_d      = len_q;
      idx_d      = idx_q;
      done_d     = done_q;
      err_d      = err_q | ((state_q != StIdle) && (state_q != StDone));
    end
  end

  // State and output registers; prog_clk_en is registered so the external gate sees a clean enable.
  always_ff @(posedge prog_clk) begin
    if (reset) begin
      state_q    <= StIdle;
      bits_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      rb_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      pclk_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bits_q     <= bits_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      rb_valid_q <= rb_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      pclk_en_q  <= (state_d == StShift);
    end
  end

  ccff_word_serializer #(
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W)
  ) u_serializer (
    .clk_i     (prog_clk),
    .rst_i     (reset),
    .load_i    (load),
    .shift_i   (shift),
    .data_i    (cfg_data),
    .bit_idx_i (idx_q),
    .tail_i    (ccff_tail),
    .head_o    (ccff_head),
    .capture_o (capture)
  );

endmodule
